// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - parametrised N-way write-back, write-allocate data cache
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss/write-back counters.
module dcache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_we,
    input  logic [ADDR_W-1:0]       cpu_req_addr,
    input  logic [31:0]             cpu_req_wdata,
    input  logic [3:0]              cpu_req_wstrb,
    output logic                    cpu_resp_valid,
    output logic [31:0]             cpu_resp_rdata,
    output logic                    mem_rd_valid,
    input  logic                    mem_rd_ready,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic                    mem_rd_resp_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rd_resp_data,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic [32*LINE_WORDS-1:0] wb_data
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hit_cnt,
    output logic [31:0]             perf_miss_cnt,
    output logic [31:0]             perf_wb_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WO_W   = $clog2(LINE_WORDS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL_REQ, S_REFILL_WAIT} state_t;
    state_t r_state, w_next;

    logic [LINE_W-1:0] r_data  [WAYS][SETS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];

    logic              r_we;
    logic [ADDR_W-1:2] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [WAY_W-1:0]  r_victim;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WO_W-1:0]   w_word;
    logic              w_hit, w_inv_found, w_lookup_hit, w_refill;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_lru_way, w_vict;
    logic [LINE_W-1:0] w_hit_line, w_merged;
    logic              w_unused;

    assign w_idx    = r_addr[OFF_W +: IDX_W];
    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word   = r_addr[2 +: WO_W];
    assign w_unused = ^cpu_req_addr[1:0];

    // Descending scan so the lowest-index hit/invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w][w_idx]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_vict       = w_inv_found ? w_inv_way : w_lru_way;
    assign w_hit_line   = r_data[w_hit_way][w_idx];
    assign w_lookup_hit = !reset && r_state == S_LOOKUP && w_hit;
    assign w_refill     = !reset && r_state == S_REFILL_WAIT && mem_rd_resp_valid;

    always_comb begin
        w_merged = w_hit_line;
        for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) w_merged[{w_word, 5'd0} + b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    generate
        if (WAYS == 4) begin : g_plru
            // bit0: left pair used last; bit1: way0 used last; bit2: way2 used last
            logic [2:0] r_plru [SETS];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
                end else if (w_lookup_hit) begin
                    r_plru[w_idx][0] <= ~w_hit_way[1];
                    if (w_hit_way[1]) r_plru[w_idx][2] <= ~w_hit_way[0];
                    else              r_plru[w_idx][1] <= ~w_hit_way[0];
                end
            end
            assign w_lru_way = r_plru[w_idx][0] ? {1'b1, r_plru[w_idx][2]} : {1'b0, r_plru[w_idx][1]};
        end else if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] r_mru;
            always_ff @(posedge clk) begin
                if (reset)             r_mru <= '0;
                else if (w_lookup_hit) r_mru[w_idx] <= w_hit_way[0];
            end
            assign w_lru_way = ~r_mru[w_idx];
        end else begin : g_dm
            assign w_lru_way = '0;
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (cpu_req_valid) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)                                             w_next = S_IDLE;
                else if (r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx]) w_next = S_WRITEBACK;
                else                                                   w_next = S_REFILL_REQ;
            end
            S_WRITEBACK:   if (wb_ready)          w_next = S_REFILL_REQ;
            S_REFILL_REQ:  if (mem_rd_ready)      w_next = S_REFILL_WAIT;
            S_REFILL_WAIT: if (mem_rd_resp_valid) w_next = S_LOOKUP;
            default:                              w_next = S_IDLE;
        endcase
    end

    assign cpu_req_ready  = !reset && r_state == S_IDLE;
    assign cpu_resp_valid = w_lookup_hit;
    assign cpu_resp_rdata = (w_lookup_hit && !r_we) ? w_hit_line[{w_word, 5'd0} +: 32] : 32'd0;
    assign mem_rd_valid   = !reset && r_state == S_REFILL_REQ;
    assign mem_rd_addr    = mem_rd_valid ? {w_tag, w_idx, {OFF_W{1'b0}}} : '0;
    assign wb_valid       = !reset && r_state == S_WRITEBACK;
    assign wb_addr        = wb_valid ? {r_tag[r_victim][w_idx], w_idx, {OFF_W{1'b0}}} : '0;
    assign wb_data        = wb_valid ? r_data[r_victim][w_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_lookup_hit && r_we) r_dirty[w_hit_way][w_idx] <= 1'b1;
            if (w_refill) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
        end
    end

    // Request, victim and line storage carry no reset.
    always_ff @(posedge clk) begin
        if (cpu_req_ready && cpu_req_valid) begin
            r_we    <= cpu_req_we;
            r_addr  <= cpu_req_addr[ADDR_W-1:2];
            r_wdata <= cpu_req_wdata;
            r_wstrb <= cpu_req_wstrb;
        end
        if (!reset && r_state == S_LOOKUP && !w_hit) r_victim <= w_vict;
        if (w_lookup_hit && r_we) r_data[w_hit_way][w_idx] <= w_merged;
        if (w_refill) begin
            r_data[r_victim][w_idx] <= mem_rd_resp_data;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        r_first_lookup;
    logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_lookup <= 1'b0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
            r_wb_cnt       <= '0;
        end else begin
            if (cpu_req_ready && cpu_req_valid) r_first_lookup <= 1'b1;
            if (r_state == S_LOOKUP) begin
                r_first_lookup <= 1'b0;
                if (r_first_lookup && w_hit && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + 32'd1;
                if (r_first_lookup && !w_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (wb_valid && wb_ready && r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 32'd1;
        end
    end
    assign perf_hit_cnt  = r_hit_cnt;
    assign perf_miss_cnt = r_miss_cnt;
    assign perf_wb_cnt   = r_wb_cnt;
`endif
endmodule

// File: tb/tb_dcache_nway.sv
// tb/tb_dcache_nway.sv - randomized bench for dcache_nway against an LRU-stack cache model
module tb_dcache_nway;
    localparam int WAYS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic [3:0]   cpu_req_wstrb;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_rd_valid, mem_rd_ready;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_resp_valid;
    logic [255:0] mem_rd_resp_data;
    logic         wb_valid, wb_ready;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;

    dcache_nway dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_resp_valid(mem_rd_resp_valid),
        .mem_rd_resp_data(mem_rd_resp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Backing memory and cache contents; each set holds line addresses, most recent first.
    logic [255:0] mem  [logic [31:0]];
    logic [255:0] cdat [logic [31:0]];
    bit           cdirty [logic [31:0]];
    logic [31:0]  mru_la [256][WAYS];
    int           ncnt [256];

    logic [31:0] last_rdata, last_rd_addr, last_wb_addr;
    bit          last_saw_rd, last_saw_wb;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = la ^ (32'h0101_0000 * (i + 1));
        return l;
    endfunction

    function automatic int find_line(input int s, input logic [31:0] la);
        for (int i = 0; i < ncnt[s]; i++) if (mru_la[s][i] == la) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 256; s++) ncnt[s] = 0;
        cdat.delete();
        cdirty.delete();
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int wb_hold, input bit abort);
        logic [31:0]  la, vla, exp_rd;
        logic [255:0] refl, wbl, nl;
        int s, wi, pos, low_cnt, rsp_cnt, cyc;
        bit hit, exp_wb, wb_hs, rd_hs, wb_done, rd_done, resp_sent, resp_given, done, aborted;
        la = {addr[31:5], 5'd0};
        s  = int'(addr[12:5]);
        wi = int'(addr[4:2]);
        pos = find_line(s, la);
        hit = (pos >= 0);
        exp_wb = 0; vla = '0; wbl = '0;
        if (!hit && ncnt[s] == WAYS) begin
            vla    = mru_la[s][WAYS-1];
            exp_wb = cdirty[vla];
            wbl    = cdat[vla];
        end
        refl   = hit ? cdat[la] : mem_line(la);
        exp_rd = we ? 32'd0 : refl[wi*32 +: 32];
        low_cnt = 0; rsp_cnt = 0;
        wb_hs = 0; rd_hs = 0; wb_done = 0; rd_done = 0;
        resp_sent = 0; resp_given = 0; done = 0; aborted = 0;
        last_saw_rd = 0; last_saw_wb = 0; last_rdata = '0; last_rd_addr = '0; last_wb_addr = '0;

        chk("req_ready", cpu_req_ready, 1);
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr;
        cpu_req_wdata = wd; cpu_req_wstrb = ws;
        mem_rd_resp_valid = ($urandom_range(0, 1) == 1);
        mem_rd_resp_data  = {8{$urandom}};
        @(negedge clk);
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_wdata = $urandom; cpu_req_wstrb = 4'($urandom);
        mem_rd_resp_valid = 0;
        for (cyc = 0; cyc < 400 && !done; cyc++) begin
            if (wb_hs) begin
                wb_hs = 0; wb_done = 1; mem[vla] = wbl;
                chk("rd_after_wb", mem_rd_valid, 1);
            end
            if (rd_hs) begin
                rd_hs = 0; rd_done = 1; rsp_cnt = $urandom_range(0, 3);
            end
            if (resp_sent) begin
                resp_sent = 0; mem_rd_resp_valid = 0;
                chk("replay_lat", cpu_resp_valid, 1);
            end
            if (cpu_resp_valid) begin
                last_rdata = cpu_resp_rdata;
                chk("rdata", cpu_resp_rdata, exp_rd);
                chk("miss_path", {wb_done, rd_done}, {exp_wb, !hit});
                if (hit) chk("hit_lat", cyc, 0);
                done = 1;
            end else begin
                if (wb_valid) begin
                    last_saw_wb = 1; last_wb_addr = wb_addr;
                    chk("wb_valid", wb_valid, exp_wb && !wb_done);
                    chk("wb_addr", wb_addr, vla);
                    chk("wb_data", wb_data, wbl);
                    chk("wb_rd_excl", mem_rd_valid, 0);
                end
                if (mem_rd_valid) begin
                    last_saw_rd = 1; last_rd_addr = mem_rd_addr;
                    chk("rd_valid", mem_rd_valid, !hit && !rd_done && (wb_done || !exp_wb));
                    chk("rd_addr", mem_rd_addr, la);
                end
                if (wb_valid && low_cnt < wb_hold) begin
                    wb_ready = 0; low_cnt++;
                end else begin
                    wb_ready = ($urandom_range(0, 1) == 1);
                end
                mem_rd_ready = ($urandom_range(0, 1) == 1);
                wb_hs = wb_valid && wb_ready;
                rd_hs = mem_rd_valid && mem_rd_ready;
                if (rd_done && !resp_given) begin
                    if (rsp_cnt > 0) begin
                        rsp_cnt--;
                    end else if (abort) begin
                        reset = 1;
                        @(negedge clk);
                        chk("abort_resp", cpu_resp_valid, 0);
                        chk("abort_ready", cpu_req_ready, 0);
                        chk("abort_valids", {mem_rd_valid, wb_valid}, 0);
                        reset = 0;
                        @(negedge clk);
                        chk("abort_ready_post", cpu_req_ready, 1);
                        chk("abort_noresp", cpu_resp_valid, 0);
                        model_clear();
                        aborted = 1; done = 1;
                    end else begin
                        mem_rd_resp_valid = 1; mem_rd_resp_data = refl;
                        resp_sent = 1; resp_given = 1;
                    end
                end
                if (!done) @(negedge clk);
            end
        end
        if (!done) chk("timeout", done, 1);
        if (done && !aborted) begin
            if (!hit) begin
                if (ncnt[s] == WAYS) begin
                    cdat.delete(vla); cdirty.delete(vla); ncnt[s]--;
                end
                for (int i = WAYS - 1; i > 0; i--) mru_la[s][i] = mru_la[s][i-1];
                mru_la[s][0] = la; ncnt[s]++;
                cdat[la] = refl; cdirty[la] = 0;
            end else begin
                for (int i = pos; i > 0; i--) mru_la[s][i] = mru_la[s][i-1];
                mru_la[s][0] = la;
            end
            if (we) begin
                nl = cdat[la];
                for (int b = 0; b < 4; b++) if (ws[b]) nl[wi*32 + b*8 +: 8] = wd[b*8 +: 8];
                cdat[la] = nl; cdirty[la] = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] l0;
        logic [31:0]  a;
        reset = 1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0;
        cpu_req_wdata = '0; cpu_req_wstrb = '0; mem_rd_ready = 0;
        mem_rd_resp_valid = 0; mem_rd_resp_data = '0; wb_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_ready", cpu_req_ready, 0);
        chk("rst_valids", {cpu_resp_valid, mem_rd_valid, wb_valid}, 0);
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", cpu_req_ready, 1);
        chk("post_rst_outs", {cpu_resp_valid, cpu_resp_rdata, mem_rd_valid, mem_rd_addr, wb_valid, wb_addr}, 0);
        chk("post_rst_wbdata", wb_data, 0);

        for (int i = 0; i < 8; i++) l0[i*32 +: 32] = 32'hA0 + i;
        mem[32'h0000_1000] = l0;
        do_req(0, 32'h0000_1004, 32'h0, 4'h0, 0, 0);
        chk("tp_cold_rdata", last_rdata, 32'hA1);
        chk("tp_cold_addr", last_rd_addr, 32'h0000_1000);
        do_req(0, 32'h0000_1008, 32'h0, 4'h0, 0, 0);
        chk("tp_hit_rdata", last_rdata, 32'hA2);
        chk("tp_hit_nomem", last_saw_rd, 0);
        do_req(1, 32'h0000_1004, 32'h1122_3344, 4'b0011, 0, 0);
        do_req(0, 32'h0000_1004, 32'h0, 4'h0, 0, 0);
        chk("tp_store_merge", last_rdata, 32'h0000_3344);

        do_req(1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_req(0, 32'h0000_2000, 32'h0, 4'h0, 0, 0);
        do_req(0, 32'h0000_2004, 32'h0, 4'h0, 0, 0);
        do_req(0, 32'h0000_6000, 32'h0, 4'h0, 5, 0);
        chk("tp_wb_seen", last_saw_wb, 1);
        chk("tp_wb_addr", last_wb_addr, 32'h0000_4000);

        do_req(0, 32'h0000_8004, 32'h0, 4'h0, 0, 1);
        do_req(0, 32'h0000_8004, 32'h0, 4'h0, 0, 0);
        chk("tp_abort_remiss", last_saw_rd, 1);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 4) << 13) | ($urandom_range(0, 2) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
